// File: rtl/alu_pkg.sv
// alu_pkg: opcode/buffer-state types and the 16-op ALU function shared by alu_arbiter.
package alu_pkg;
   localparam int RES_W = 8;
   typedef enum logic [3:0] {
      OP_ORR, OP_ANDR, OP_XORR, OP_AND, OP_OR, OP_XOR, OP_GT, OP_LT,
      OP_NOT, OP_EQ, OP_ADD, OP_SUB, OP_MUL, OP_SHR, OP_SHL, OP_INV
   } alu_op_t;
   typedef enum logic {EMPTY, FULL} buf_state_t;
   function automatic logic [RES_W-1:0] alu_eval(alu_op_t op, logic [3:0] a, logic [3:0] b);
      logic [RES_W-1:0] a8;
      a8 = {4'b0, a};
      case (op)
         OP_ORR:  return {7'b0, |a};
         OP_ANDR: return {7'b0, &a};
         OP_XORR: return {7'b0, ^a};
         OP_AND:  return {4'b0, a & b};
         OP_OR:   return {4'b0, a | b};
         OP_XOR:  return {4'b0, a ^ b};
         OP_GT:   return {7'b0, a > b};
         OP_LT:   return {7'b0, a < b};
         OP_NOT:  return {7'b0, ~|a};
         OP_EQ:   return {7'b0, a == b};
         OP_ADD:  return {3'b0, {1'b0, a} + {1'b0, b}};
         OP_SUB:  return {4'b0, a - b};
         OP_MUL:  return a8 * {4'b0, b};
         OP_SHR:  return {4'b0, a >> b};
         OP_SHL:  return a8 << b;
         default: return {4'b0, ~a};
      endcase
   endfunction
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational two-way round-robin picker; prio_ptr names the winner on contention.
module rr_pick2 (
   input  logic valid0,
   input  logic valid1,
   input  logic prio_ptr,
   output logic grant0,
   output logic grant1,
   output logic contested
);
   assign contested = valid0 && valid1;
   assign grant0    = valid0 && (!valid1 || !prio_ptr);
   assign grant1    = valid1 && (!valid0 || prio_ptr);
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of one ALU slot between two requesters, one-entry result buffer.
// Optional counters enabled by defining ALU_ARB_STATS_EN.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int ID_W = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [3:0]       req0_op,
   input  logic [3:0]       req0_a,
   input  logic [3:0]       req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [3:0]       req1_op,
   input  logic [3:0]       req1_a,
   input  logic [3:0]       req1_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [ID_W-1:0]  rsp_id,
   output logic [RES_W-1:0] rsp_result
`ifdef ALU_ARB_STATS_EN
   ,
   input  logic             stats_clr,
   output logic [15:0]      grant_cnt0,
   output logic [15:0]      grant_cnt1,
   output logic [15:0]      stall_cnt
`endif
);
   buf_state_t       state_q, state_d;
   logic             prio_q, prio_d;
   logic [ID_W-1:0]  id_q, id_d;
   logic [RES_W-1:0] res_q, res_d;
   logic             grant0, grant1, contested, can_accept, go;

   rr_pick2 u_pick (
      .valid0   (req0_valid),
      .valid1   (req1_valid),
      .prio_ptr (prio_q),
      .grant0   (grant0),
      .grant1   (grant1),
      .contested(contested)
   );

   // Readies are gated by rst_n so nothing is accepted while reset is held.
   always_comb begin
      can_accept = (state_q == EMPTY) || rsp_ready;
      req0_ready = rst_n && can_accept && grant0;
      req1_ready = rst_n && can_accept && grant1;
      go         = req0_ready || req1_ready;
      state_d    = go ? FULL : (rsp_ready ? EMPTY : state_q);
      prio_d     = (go && contested) ? grant0 : prio_q;
      id_d       = go ? ID_W'(grant1) : id_q;
      res_d      = !go ? res_q :
                   grant1 ? alu_eval(alu_op_t'(req1_op), req1_a, req1_b)
                          : alu_eval(alu_op_t'(req0_op), req0_a, req0_b);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         prio_q  <= 1'b0;
         id_q    <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         prio_q  <= prio_d;
         id_q    <= id_d;
         res_q   <= res_d;
      end
   end

   assign rsp_valid  = state_q == FULL;
   assign rsp_id     = id_q;
   assign rsp_result = res_q;

`ifdef ALU_ARB_STATS_EN
   logic [15:0] grant_cnt0_q, grant_cnt0_d, grant_cnt1_q, grant_cnt1_d, stall_cnt_q, stall_cnt_d;

   always_comb begin
      grant_cnt0_d = stats_clr ? '0 : grant_cnt0_q + 16'(req0_ready && grant_cnt0_q != '1);
      grant_cnt1_d = stats_clr ? '0 : grant_cnt1_q + 16'(req1_ready && grant_cnt1_q != '1);
      stall_cnt_d  = stats_clr ? '0 : stall_cnt_q + 16'(rsp_valid && !rsp_ready && stall_cnt_q != '1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         grant_cnt0_q <= '0;
         grant_cnt1_q <= '0;
         stall_cnt_q  <= '0;
      end else begin
         grant_cnt0_q <= grant_cnt0_d;
         grant_cnt1_q <= grant_cnt1_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

   assign grant_cnt0 = grant_cnt0_q;
   assign grant_cnt1 = grant_cnt1_q;
   assign stall_cnt  = stall_cnt_q;
`endif
endmodule
